// File: rtl/mult_error_sweeper.sv
// Exhaustive error sweep of a W x W truncated array multiplier: accumulates absolute
// and F-bit relative error over every operand pair using a serial restoring divider.
module mult_error_sweeper #(
  parameter int W = 4,
  parameter int K = 2,
  parameter int F = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*W:0]       pairs_tested,
  output logic [4*W-1:0]     sum_abs_err,
  output logic [2*W-1:0]     max_abs_err,
  output logic [2*W:0]       err_count,
  output logic [F+2*W-1:0]   sum_rel_err
);

  localparam int PW  = 2 * W;
  localparam int CW  = 2 * W + 1;
  localparam int SW  = 4 * W;
  localparam int RW  = F + 2 * W;
  localparam int DCW = $clog2(F + 1);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_DIV, S_NEXT, S_DONE} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_cnt;
  logic [PW-1:0]    r_rem;
  logic [F-1:0]     r_quo;
  logic [DCW-1:0]   r_dcnt;

  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [PW-1:0]    w_exact;
  logic [PW-1:0]    w_approx;
  logic [PW-1:0]    w_err;
  logic [PW:0]      w_rem_sh;
  logic             w_ge;
  logic [PW-1:0]    w_rem_nx;
  logic [F-1:0]     w_quo_nx;

  // Partial-product bits in columns below K are simply dropped.
  function automatic logic [PW-1:0] trunc_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (i + j >= K) acc = acc + (PW'(a[i] & b[j]) << (i + j));
      end
    end
    return acc;
  endfunction

  assign w_a      = r_cnt[PW-1:W];
  assign w_b      = r_cnt[W-1:0];
  assign w_exact  = PW'(w_a) * PW'(w_b);
  assign w_approx = trunc_mult(w_a, w_b);
  assign w_err    = w_exact - w_approx;

  // Remainder never exceeds exact, so the doubled value fits in PW+1 bits.
  assign w_rem_sh = {r_rem, 1'b0};
  assign w_ge     = (w_rem_sh >= {1'b0, w_exact});
  assign w_rem_nx = w_ge ? PW'(w_rem_sh - {1'b0, w_exact}) : w_rem_sh[PW-1:0];
  assign w_quo_nx = (r_quo << 1) | F'(w_ge);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dcnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pairs_tested <= '0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      err_count    <= '0;
      sum_rel_err  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_EVAL;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dcnt       <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pairs_tested <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            err_count    <= '0;
            sum_rel_err  <= '0;
          end
        end
        S_EVAL: begin
          sum_abs_err  <= sum_abs_err + SW'(w_err);
          pairs_tested <= pairs_tested + CW'(1);
          if (w_err > max_abs_err) max_abs_err <= w_err;
          if (w_err != '0) begin
            err_count <= err_count + CW'(1);
            r_rem     <= w_err;
            r_quo     <= '0;
            r_dcnt    <= '0;
            r_state   <= S_DIV;
          end else begin
            r_state   <= S_NEXT;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_dcnt == DCW'(F - 1)) begin
            sum_rel_err <= sum_rel_err + RW'(w_quo_nx);
            r_state     <= S_NEXT;
          end else begin
            r_dcnt <= r_dcnt + DCW'(1);
          end
        end
        S_NEXT: begin
          if (r_cnt == '1) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + PW'(1);
            r_state <= S_EVAL;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_error_sweeper.sv
// Directed bench for mult_error_sweeper: a K=2 and a K=0 instance, with expected sweep
// results produced by a behavioural model and queued as a scoreboard.
module tb_mult_error_sweeper;

  localparam int W = 4;
  localparam int F = 8;
  localparam int N = 1 << (2 * W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, busy, done;
  logic [2*W:0]       pairs_tested, err_count;
  logic [4*W-1:0]     sum_abs_err;
  logic [2*W-1:0]     max_abs_err;
  logic [F+2*W-1:0]   sum_rel_err;

  logic               rst0, start0, busy0, done0;
  logic [2*W:0]       pairs_tested0, err_count0;
  logic [4*W-1:0]     sum_abs_err0;
  logic [2*W-1:0]     max_abs_err0;
  logic [F+2*W-1:0]   sum_rel_err0;

  mult_error_sweeper #(.W(W), .K(2), .F(F)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pairs_tested(pairs_tested), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
    .err_count(err_count), .sum_rel_err(sum_rel_err)
  );

  mult_error_sweeper #(.W(W), .K(0), .F(F)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
    .pairs_tested(pairs_tested0), .sum_abs_err(sum_abs_err0), .max_abs_err(max_abs_err0),
    .err_count(err_count0), .sum_rel_err(sum_rel_err0)
  );

  typedef struct {
    longint pairs;
    longint sabs;
    longint mx;
    longint ecnt;
    longint srel;
    longint lat;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int tmul(input int a, input int b, input int k);
    int acc = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j >= k && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1) acc += (1 << (i + j));
    return acc;
  endfunction

  // floor(err*2^F/exact); an F-bit quotient tops out at 2^F-1 when err equals exact.
  function automatic int rel_of(input int a, input int b, input int k);
    int ex, er, q;
    ex = a * b;
    er = ex - tmul(a, b, k);
    if (er == 0) return 0;
    q = (er << F) / ex;
    if (q > (1 << F) - 1) q = (1 << F) - 1;
    return q;
  endfunction

  function automatic longint rel_cum(input int k, input int last);
    longint s = 0;
    for (int idx = 0; idx <= last; idx++) s += rel_of(idx / (1 << W), idx % (1 << W), k);
    return s;
  endfunction

  function automatic exp_t model(input int k);
    exp_t e;
    int er;
    e = '{default: 0};
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        er = a * b - tmul(a, b, k);
        e.pairs++;
        e.sabs += er;
        if (er > e.mx) e.mx = er;
        if (er != 0) e.ecnt++;
        e.srel += rel_of(a, b, k);
      end
    end
    e.lat = 2 * N + F * e.ecnt;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int sel, input int lim, inout int n);
    while (((sel == 0) ? done0 : done) !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    check("done_within_bound", ((sel == 0) ? done0 : done), 1);
  endtask

  task automatic wait_pairs(input longint target, input int lim);
    int n = 0;
    while (pairs_tested != target && n < lim) begin
      tick();
      n++;
    end
    check("reach_pairs", pairs_tested, target);
  endtask

  task automatic compare_result(input string tag, input int sel, input int n);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, n, e.lat);
    if (sel == 0) begin
      check({tag, "_pairs"}, pairs_tested0, e.pairs);
      check({tag, "_sum_abs"}, sum_abs_err0, e.sabs);
      check({tag, "_max_abs"}, max_abs_err0, e.mx);
      check({tag, "_err_count"}, err_count0, e.ecnt);
      check({tag, "_sum_rel"}, sum_rel_err0, e.srel);
      check({tag, "_busy"}, busy0, 0);
    end else begin
      check({tag, "_pairs"}, pairs_tested, e.pairs);
      check({tag, "_sum_abs"}, sum_abs_err, e.sabs);
      check({tag, "_max_abs"}, max_abs_err, e.mx);
      check({tag, "_err_count"}, err_count, e.ecnt);
      check({tag, "_sum_rel"}, sum_rel_err, e.srel);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pairs"}, pairs_tested, 0);
    check({tag, "_sum_abs"}, sum_abs_err, 0);
    check({tag, "_max_abs"}, max_abs_err, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_sum_rel"}, sum_rel_err, 0);
  endtask

  initial begin
    int n;
    longint s_a, s_b, held;

    rst = 1'b1; start = 1'b0; rst0 = 1'b1; start0 = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_k0_busy", busy0, 0);
    check("reset_k0_done", done0, 0);

    // start held high during reset must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all_zero("rst_over_start");
    rst = 1'b0; rst0 = 1'b0;
    repeat (5) tick();
    check("idle_after_release_busy", busy, 0);
    check("idle_after_release_pairs", pairs_tested, 0);

    // exact multiplier: no error anywhere
    sb_q.push_back(model(0));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("k0_busy_after_start", busy0, 1);
    n = 0;
    wait_done(0, 4000, n);
    compare_result("k0_sweep", 0, n);
    check("k0_latency_512", n, 512);

    // K=2 baseline sweep
    sb_q.push_back(model(2));
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    wait_done(1, 4000, n);
    compare_result("k2_sweep", 1, n);
    check("k2_latency_1536", n, 1536);
    check("k2_pairs_256", pairs_tested, 256);
    check("k2_sum_abs_320", sum_abs_err, 320);
    check("k2_max_abs_5", max_abs_err, 5);
    check("k2_err_count_128", err_count, 128);
    held = sum_rel_err;
    repeat (5) tick();
    check("done_held", done, 1);
    check("done_hold_sum_rel", sum_rel_err, held);
    check("done_hold_sum_abs", sum_abs_err, 320);

    // restart from DONE, with a stray start pulse mid-sweep
    sb_q.push_back(model(2));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done_drops", done, 0);
    check("restart_busy", busy, 1);
    check("restart_pairs_clear", pairs_tested, 0);
    check("restart_sum_abs_clear", sum_abs_err, 0);
    check("restart_sum_rel_clear", sum_rel_err, 0);
    n = 0;
    repeat (9) begin tick(); n++; end
    start = 1'b1;
    tick();
    n++;
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    wait_done(1, 4000, n);
    compare_result("k2_restart_sweep", 1, n);

    // relative error contributed by pair A=3,B=3
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pairs(52, 2000);
    s_a = sum_rel_err;
    check("rel_before_pair51", s_a, rel_cum(2, 50));
    wait_pairs(53, 100);
    s_b = sum_rel_err;
    check("rel_pair51_quotient", s_b - s_a, 142);
    check("rel_through_pair51", s_b, rel_cum(2, 51));

    // reset in the middle of a division
    wait_pairs(54, 100);
    repeat (3) tick();
    check("mid_div_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_div_reset");
    repeat (4) tick();
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_idle_pairs", pairs_tested, 0);

    sb_q.push_back(model(2));
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    wait_done(1, 4000, n);
    compare_result("k2_after_reset_sweep", 1, n);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_error_sweeper.md
MULT_ERROR_SWEEPER -- requirements
Module: mult_error_sweeper

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range 2..8.
REQ-002 Parameter K, default 2, number of truncated low partial-product columns; legal range 0..2W-1.
REQ-003 Parameter F, default 8, fractional bits of the per-pair relative error; legal range 1..16.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  begins a full sweep when sampled high in IDLE or DONE.
REQ-007 busy  output  1  high in EVAL, DIV and NEXT.
REQ-008 done  output  1  high in DONE; held until the next start or rst.
REQ-009 pairs_tested  output  2W+1  number of operand pairs evaluated.
REQ-010 sum_abs_err  output  4W  sum of |exact - approx| over evaluated pairs.
REQ-011 max_abs_err  output  2W  largest |exact - approx| seen.
REQ-012 err_count  output  2W+1  number of pairs with nonzero error.
REQ-013 sum_rel_err  output  F+2W  sum of floor(err*2^F/exact) over pairs with nonzero error.

Function
REQ-014 The block SHALL contain an internal W x W truncated array multiplier: approx = sum of partial-product bits A[i]&B[j] with i+j >= K; exact = A*B, 2W bits.
REQ-015 err SHALL be exact - approx, which is always >= 0; unsigned arithmetic only.
REQ-016 A 2W-bit pair counter cnt SHALL drive A = cnt[2W-1:W] and B = cnt[W-1:0].
REQ-017 FSM states SHALL be IDLE, EVAL, DIV, NEXT and DONE; reset state is IDLE.
REQ-018 IDLE or DONE with start=1: clear all result outputs and cnt, clear done, go to EVAL.
REQ-019 EVAL (1 cycle) SHALL:
- add err to sum_abs_err
- update max_abs_err
- increment pairs_tested
- increment err_count if err != 0
- go to DIV if err != 0, else go to NEXT.
REQ-020 DIV SHALL run exactly F cycles of restoring division of err by exact:
- shift remainder left 1, subtract exact when remainder >= exact, shift the quotient bit in.
- on the F-th cycle, add the F-bit quotient to sum_rel_err and go to NEXT.
REQ-021 Pairs with exact = 0 SHALL have err = 0 and SHALL NOT enter DIV; no division by zero can occur.
REQ-022 NEXT SHALL go to DONE when cnt = 2^(2W)-1; otherwise it increments cnt and goes to EVAL.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Total sweep latency, from the start edge to done visible, SHALL be 2*2^(2W) + F*err_count cycles.
REQ-025 Result outputs SHALL be registered; they update only in EVAL/DIV and hold their values in DONE.
REQ-026 No accumulator SHALL wrap; the widths in REQ-009..013 cover the full-sweep worst case.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE and clear busy, done, cnt, DIV state and all result outputs to 0, regardless of current state.
REQ-028 rst SHALL take priority over start on the same edge.
REQ-029 After rst is released, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-030 W=4, K=0, start pulse -> done exactly 512 cycles after the start edge; pairs_tested=256; sum_abs_err=0; max_abs_err=0; err_count=0; sum_rel_err=0.
REQ-031 W=4, K=2, F=8, start pulse -> done after 1536 cycles; pairs_tested=256; sum_abs_err=320; max_abs_err=5 (A=3, B=3: exact 9, approx 4); err_count=128.
REQ-032 W=4, K=2, stop the sweep after pair A=3, B=3 and check that pair's DIV step -> quotient 142 (floor(5*256/9)) is added to sum_rel_err.
REQ-033 W=4, K=2, pulse start again 10 cycles into the sweep -> no restart; final results identical to REQ-031.
REQ-034 W=4, K=2, assert rst mid-DIV for one cycle -> next cycle all outputs 0 and state IDLE; a subsequent start gives results identical to REQ-031.
REQ-035 W=4, K=2, start in DONE -> outputs clear on the next edge, done drops, and a second identical sweep reproduces the REQ-031 values.
